// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared types and constants for the JK key sequencer.
//                - state_t : sequencer FSM state encoding
//                - CMD_*   : {j,k} command codes driven to the flip-flop
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_J = 2'd1,
        HOLD_K = 2'd2,
        EMIT   = 2'd3
    } state_t;

    // {j,k} command codes
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_TGL  = 2'b11;
    localparam logic [1:0] CMD_HOLD = 2'b00;

endpackage : jk_pkg
`default_nettype wire

// File: rtl/jk_key_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_key_sequencer_if
//  Description : Bundles the raw key inputs and the flip-flop command outputs
//                of the JK key sequencer.
//                - key_j_n / key_k_n : raw active-low buttons (to sequencer)
//                - j / k             : command pulses to the JK flip-flop
//                - busy / dropped    : sequencer status
//                Modports: master = key/stimulus side, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jk_key_sequencer_if;

    logic key_j_n;
    logic key_k_n;
    logic j;
    logic k;
    logic busy;
    logic dropped;

    modport master (
        output key_j_n,
        output key_k_n,
        input  j,
        input  k,
        input  busy,
        input  dropped
    );

    modport slave (
        input  key_j_n,
        input  key_k_n,
        output j,
        output k,
        output busy,
        output dropped
    );

endinterface : jk_key_sequencer_if
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser, debounce filter and press detector
//                for one active-low push button.
//                - clk, rst  : clock, asynchronous active-high reset
//                - i_key_n   : raw active-low key, asynchronous to clk
//                - o_press   : one-cycle pulse, cycle after stable goes 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_n,
    output logic      o_press
);
    import jk_pkg::*;

    localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  c_DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Synchroniser: straight flop-to-flop, idle level is released (1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the new level must persist DEBOUNCE_CYCLES consecutive
    // cycles; any agreeing cycle restarts the count. The counter stops at
    // DEBOUNCE_CYCLES-1, so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == c_DB_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Press pulse one cycle after stable falls; releases are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
        end
    end

    assign o_press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/jk_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : jk_key_sequencer
//  Description : Debounces the J and K keys, pairs near-simultaneous presses
//                into a toggle and emits registered j/k command pulses to a
//                JK flip-flop (10 set, 01 reset, 11 toggle).
//                - clk, rst        : clock, asynchronous active-high reset
//                - bus.key_j_n/k_n : raw active-low keys
//                - bus.j / bus.k   : registered command outputs
//                - bus.busy        : FSM not IDLE
//                - bus.dropped     : one-cycle pulse on a discarded press
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_key_sequencer
    import jk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PAIR_WINDOW     = 250000,
    parameter int PULSE_LEN       = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    jk_key_sequencer_if.slave  bus
);

    localparam int             WW         = (PAIR_WINDOW > 1) ? $clog2(PAIR_WINDOW) : 1;
    localparam int             PW         = (PULSE_LEN   > 1) ? $clog2(PULSE_LEN)   : 1;
    localparam logic [WW-1:0]  c_WIN_LAST = WW'(PAIR_WINDOW - 1);
    localparam logic [PW-1:0]  c_PUL_LAST = PW'(PULSE_LEN - 1);

    logic          w_press_j;
    logic          w_press_k;

    state_t        r_state,   w_state_nxt;
    logic [1:0]    r_code,    w_code_nxt;
    logic [WW-1:0] r_wcnt,    w_wcnt_nxt;
    logic [PW-1:0] r_pcnt,    w_pcnt_nxt;
    logic          r_dropped, w_dropped_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_j (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (bus.key_j_n),
        .o_press (w_press_j)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_k (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (bus.key_k_n),
        .o_press (w_press_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_code    <= CMD_HOLD;
            r_wcnt    <= '0;
            r_pcnt    <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_dropped <= w_dropped_nxt;
        end
    end

    // The code register is loaded on the same edge the FSM enters EMIT and
    // cleared on the edge it leaves, so j/k are nonzero exactly while in EMIT.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_wcnt_nxt    = r_wcnt;
        w_pcnt_nxt    = '0;
        w_dropped_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_code_nxt = CMD_HOLD;
                if (w_press_j && w_press_k) begin
                    w_code_nxt  = CMD_TGL;
                    w_state_nxt = EMIT;
                end else if (w_press_j) begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = HOLD_J;
                end else if (w_press_k) begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = HOLD_K;
                end
            end
            HOLD_J: begin
                // A second press of the same key has nowhere to go
                w_dropped_nxt = w_press_j;
                if (w_press_k) begin
                    w_code_nxt  = CMD_TGL;
                    w_state_nxt = EMIT;
                end else if (r_wcnt == c_WIN_LAST) begin
                    w_code_nxt  = CMD_SET;
                    w_state_nxt = EMIT;
                end else begin
                    w_wcnt_nxt  = r_wcnt + 1'b1;
                end
            end
            HOLD_K: begin
                w_dropped_nxt = w_press_k;
                if (w_press_j) begin
                    w_code_nxt  = CMD_TGL;
                    w_state_nxt = EMIT;
                end else if (r_wcnt == c_WIN_LAST) begin
                    w_code_nxt  = CMD_RST;
                    w_state_nxt = EMIT;
                end else begin
                    w_wcnt_nxt  = r_wcnt + 1'b1;
                end
            end
            EMIT: begin
                w_dropped_nxt = w_press_j | w_press_k;
                if (r_pcnt == c_PUL_LAST) begin
                    w_code_nxt  = CMD_HOLD;
                    w_state_nxt = IDLE;
                end else begin
                    w_pcnt_nxt  = r_pcnt + 1'b1;
                end
            end
            default: begin
                w_code_nxt  = CMD_HOLD;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.j       = r_code[1];
    assign bus.k       = r_code[0];
    assign bus.busy    = (r_state != IDLE);
    assign bus.dropped = r_dropped;

endmodule : jk_key_sequencer
`default_nettype wire

// File: tb/tb_jk_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_key_sequencer
//  Description : Directed self-checking bench for jk_key_sequencer with
//                DEBOUNCE_CYCLES=4, PAIR_WINDOW=8, PULSE_LEN=2.
//                Cycle c counts the rising edges after a key is first driven
//                low; a press lands on c=6, HOLD starts at c=7 and an
//                unpaired command appears at c=15 for two cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_key_sequencer;
    import jk_pkg::*;

    localparam int DB = 4;
    localparam int PW = 8;
    localparam int PL = 2;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_key_sequencer_if bus ();

    jk_key_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .PAIR_WINDOW     (PW),
        .PULSE_LEN       (PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {4'b0, bus.j, bus.k, bus.busy, bus.dropped};
    endfunction

    // Keys released; outputs must stay quiet while the debouncers settle
    task automatic idle_keys(input string tag, input int n);
        bus.key_j_n = 1'b1;
        bus.key_k_n = 1'b1;
        for (int c = 0; c < n; c++) begin
            tick();
            chk($sformatf("%s c%0d", tag, c), outs(), 8'h00);
        end
    endtask

    // Drive J low before edge jlow and K low before edge klow, then check
    // {j,k,busy,dropped} after every edge. b*/e* are the edges on which
    // busy rises and the command first appears.
    task automatic scenario(input string tag, input int jlow, input int klow,
                            input int n,
                            input int b1, input int e1, input logic [1:0] c1,
                            input int b2, input int e2, input logic [1:0] c2,
                            input int drop);
        logic       busy_e;
        logic [1:0] code_e;
        for (int c = 0; c < n; c++) begin
            if (c == jlow) bus.key_j_n = 1'b0;
            if (c == klow) bus.key_k_n = 1'b0;
            tick();
            busy_e = ((c >= b1) && (c < e1 + PL)) || ((c >= b2) && (c < e2 + PL));
            if ((c >= e1) && (c < e1 + PL))      code_e = c1;
            else if ((c >= e2) && (c < e2 + PL)) code_e = c2;
            else                                 code_e = CMD_HOLD;
            chk($sformatf("%s c%0d", tag, c), outs(),
                {4'b0, code_e, busy_e, (c == drop)});
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.key_j_n = 1'b1;
        bus.key_k_n = 1'b1;

        // Reset held with keys idle
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("reset c%0d", c), outs(), 8'h00);
        end
        rst = 1'b0;
        idle_keys("post_reset", 5);

        // Bounce shorter than the debounce time never becomes a press
        for (int c = 0; c < 20; c++) begin
            bus.key_j_n = ((c / 2) % 2) != 0;
            tick();
            chk($sformatf("bounce c%0d", c), outs(), 8'h00);
        end
        idle_keys("bounce_tail", 14);

        // Single J press held 50 cycles -> 10
        scenario("single_j", 0, NEVER, 50, 7, 15, CMD_SET, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_a", 14);

        // Single K press -> 01
        scenario("single_k", NEVER, 0, 30, 7, 15, CMD_RST, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_b", 14);

        // Both keys in the same cycle -> immediate toggle
        scenario("same_cycle", 0, 0, 20, 7, 7, CMD_TGL, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_c", 14);

        // K 3 cycles after J -> toggle, no preceding set
        scenario("pair_k3", 0, 3, 25, 7, 10, CMD_TGL, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_d", 14);

        // K press coincides with window expiry -> press wins
        scenario("pair_edge", 0, 8, 25, 7, 15, CMD_TGL, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_e", 14);

        // K press lands in EMIT -> set, plus a dropped pulse
        scenario("drop_emit", 0, 9, 25, 7, 15, CMD_SET, -100, -100, CMD_HOLD, 16);
        idle_keys("rel_f", 14);

        // K 12 cycles after J lands in IDLE -> set, then a separate reset
        scenario("late_pair", 0, 12, 40, 7, 15, CMD_SET, 19, 27, CMD_RST, -1);
        idle_keys("rel_g", 14);

        // Reset on the first j=1 cycle, J still held afterwards
        bus.key_j_n = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        chk("pre_rst_j", outs(), {4'b0, CMD_SET, 1'b1, 1'b0});
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", outs(), 8'h00);
        tick();
        tick();
        chk("rst_hold", outs(), 8'h00);
        rst = 1'b0;
        scenario("rehold_j", 0, NEVER, 20, 7, 15, CMD_SET, -100, -100, CMD_HOLD, -1);
        idle_keys("rel_h", 14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_jk_key_sequencer
`default_nettype wire
